branch_result_buffer: RTL

// - Decouples the branch unit from the two common data buses (CDB): queues completed branch

---
 rtl/branch_result_buffer_pkg.sv | 14 +
 rtl/branch_result_buffer_if.sv | 37 +++
 rtl/branch_result_buffer_result_fifo.sv | 51 +++++
 rtl/branch_result_buffer.sv | 68 ++++++
 4 files changed

// File: rtl/branch_result_buffer_pkg.sv
// Shared types for the branch result buffer: the queued result record
// and the number of common data buses it can drive.
package branch_result_buffer_pkg;
   localparam int XLEN      = 32;
   localparam int RRN_WIDTH = 6;
   localparam int CDB_COUNT = 2;

   typedef struct packed {
      logic [XLEN-1:0]      address;
      logic [XLEN-1:0]      store_result;
      logic [XLEN-1:0]      jump_result;
      logic [RRN_WIDTH-1:0] rrn;
   } branch_result_t;
endpackage

// File: rtl/branch_result_buffer_if.sv
// Branch unit input handshake, arbiter request/grant and CDB broadcast.
interface branch_result_buffer_if;
   import branch_result_buffer_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [XLEN-1:0]      in_address;
   logic [XLEN-1:0]      in_store_result;
   logic [XLEN-1:0]      in_jump_result;
   logic [RRN_WIDTH-1:0] in_rrn;
   logic                 get_bus;
   logic                 bus_granted;
   logic                 bus_selected;
   logic [CDB_COUNT-1:0] cdb_valid;
   logic [XLEN-1:0]      cdb_address;
   logic [XLEN-1:0]      cdb_result;
   logic [XLEN-1:0]      cdb_jmp_address;
   logic [RRN_WIDTH-1:0] cdb_rrn;

   modport master (
      output in_valid, in_address, in_store_result,
      output in_jump_result, in_rrn,
      output bus_granted, bus_selected,
      input  in_ready, get_bus,
      input  cdb_valid, cdb_address, cdb_result,
      input  cdb_jmp_address, cdb_rrn
   );

   modport slave (
      input  in_valid, in_address, in_store_result,
      input  in_jump_result, in_rrn,
      input  bus_granted, bus_selected,
      output in_ready, get_bus,
      output cdb_valid, cdb_address, cdb_result,
      output cdb_jmp_address, cdb_rrn
   );
endinterface

// File: rtl/branch_result_buffer_result_fifo.sv
// Circular DEPTH-entry queue of branch results; the extra pointer MSB
// separates full from empty when the indexes coincide.
module result_fifo
   import branch_result_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           flush,
   input  logic           push,
   input  logic           pop,
   input  branch_result_t wdata,
   output branch_result_t rdata,
   output logic           full,
   output logic           empty
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam logic [PW-1:0] ONE = PW'(1);

   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;
   branch_result_t mem [DEPTH];

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) &&
                    (wr_ptr[PW-1] != rd_ptr[PW-1]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr[IW-1:0]];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ONE;
         if (do_pop)  rd_ptr <= rd_ptr + ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[IW-1:0]] <= wdata;
   end
endmodule

// File: rtl/branch_result_buffer.sv
// Queues completed branch results and broadcasts one per arbiter grant
// onto the selected CDB through registered outputs.
module branch_result_buffer
   import branch_result_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   branch_result_buffer_if.slave  bus
);
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 grant;
   branch_result_t       wdata;
   branch_result_t       head;
   branch_result_t       cdb_q;
   logic [CDB_COUNT-1:0] cdb_valid_q;

   assign wdata = '{address:      bus.in_address,
                    store_result: bus.in_store_result,
                    jump_result:  bus.in_jump_result,
                    rrn:          bus.in_rrn};

   assign bus.in_ready = !full;
   assign bus.get_bus  = !empty;
   assign push         = bus.in_valid && !full;
   assign grant        = bus.bus_granted && !empty;

   result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (grant),
      .wdata (wdata),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // Data registers hold between grants; only the valid strobe clears.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cdb_valid_q <= '0;
         cdb_q       <= '0;
      end else begin
         cdb_valid_q <= '0;
         if (grant && !flush) begin
            cdb_valid_q <= CDB_COUNT'(1) << bus.bus_selected;
            cdb_q       <= head;
         end
      end
   end

   assign bus.cdb_valid       = cdb_valid_q;
   assign bus.cdb_address     = cdb_q.address;
   assign bus.cdb_result      = cdb_q.store_result;
   assign bus.cdb_jmp_address = cdb_q.jump_result;
   assign bus.cdb_rrn         = cdb_q.rrn;

   spurious_grant: assert property (
      @(posedge clock) disable iff (!reset)
      bus.bus_granted |-> !empty
   ) else $warning("bus_granted while result queue empty");
endmodule
